// File: rtl/apb_cfg_master_if.sv
// Command/response handshake plus APB3 bus of the configuration master.
// The master modport is the initiator's view; the slave modport is the
// opposite side (sequencer on the command port, DMA on the APB port).
interface apb_cfg_master_if #(
  parameter int ADDR_W = 13
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              pclken;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           pclken, psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           pclken, psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_cfg_master.sv
// APB3 initiator for the DMA register port. One register read or write per
// accepted command, APB phases advanced only on pclken ticks, result held on
// the response port until consumed.
//
// state  | meaning
// IDLE   | waiting for a command, req_ready high
// SETUP  | psel high, penable low, waiting for the next tick
// ACCESS | psel and penable high, waiting for pready on a tick or timeout
// RESP   | rsp_valid high, waiting for rsp_ready
module apb_cfg_master #(
  parameter int ADDR_W      = 13,
  parameter int PCLK_DIV    = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            reset,
  apb_cfg_master_if.master bus
);

  localparam int DIV_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PCLK_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CYC);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              pclken_q, pclken_d;
  logic [1:0]        state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  // Free-running divider; pclken is registered so it is low in reset and
  // rises on the edge where the count lands on its last value.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pclken_d = (div_d == DIV_LAST);
  end

  // Next-state and output-register logic; pclken_q high marks a tick edge.
  always_comb begin
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          paddr_d   = bus.req_addr & ADDR_MASK;
          pwrite_d  = bus.req_write;
          pwdata_d  = bus.req_write ? bus.req_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (pclken_q) begin
          penable_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (pclken_q) begin
          if (bus.pready) begin
            rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
            rsp_err_d     = bus.pslverr;
            rsp_timeout_d = 1'b0;
            rsp_valid_d   = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = S_RESP;
          end else if (TIMEOUT_CYC != 0) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_d == TO_LIMIT) begin
              rsp_rdata_d   = '0;
              rsp_err_d     = 1'b1;
              rsp_timeout_d = 1'b1;
              rsp_valid_d   = 1'b1;
              psel_d        = 1'b0;
              penable_d     = 1'b0;
              state_d       = S_RESP;
            end
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so it is low in reset and never re-opens in the RESP cycle.
    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset drops the bus and discards any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      pclken_q      <= 1'b0;
      state_q       <= S_IDLE;
      to_cnt_q      <= '0;
      req_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pclken_q      <= pclken_d;
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      req_ready_q   <= req_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.pclken      = pclken_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master: one instance at PCLK_DIV=1 and one at PCLK_DIV=4,
// shared stimulus steered to the selected instance, a memory-backed APB slave
// with programmable wait ticks and error, and a per-cycle protocol monitor.
module tb_apb_cfg_master;
  localparam int AW = 13;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int compared   = 0;
  int mismatched = 0;

  apb_cfg_master_if #(.ADDR_W(AW)) if1 ();
  apb_cfg_master_if #(.ADDR_W(AW)) if4 ();

  apb_cfg_master #(.ADDR_W(AW), .PCLK_DIV(1), .TIMEOUT_CYC(TO)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.master));
  apb_cfg_master #(.ADDR_W(AW), .PCLK_DIV(4), .TIMEOUT_CYC(TO)) u_dut4 (
    .clk(clk), .reset(reset), .bus(if4.master));

  logic          sel;  // 0 = DIV1 instance, 1 = DIV4 instance
  logic          req_valid, req_write, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          pready, pslverr;
  logic [31:0]   prdata;

  assign if1.req_valid = req_valid & ~sel;
  assign if4.req_valid = req_valid & sel;
  assign if1.req_write = req_write;  assign if4.req_write = req_write;
  assign if1.req_addr  = req_addr;   assign if4.req_addr  = req_addr;
  assign if1.req_wdata = req_wdata;  assign if4.req_wdata = req_wdata;
  assign if1.rsp_ready = rsp_ready;  assign if4.rsp_ready = rsp_ready;
  assign if1.prdata    = prdata;     assign if4.prdata    = prdata;
  assign if1.pready    = pready;     assign if4.pready    = pready;
  assign if1.pslverr   = pslverr;    assign if4.pslverr   = pslverr;

  logic          o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_timeout;
  logic          o_pclken, o_psel, o_penable, o_pwrite;
  logic [31:0]   o_rsp_rdata, o_pwdata;
  logic [AW-1:0] o_paddr;
  assign o_req_ready   = sel ? if4.req_ready   : if1.req_ready;
  assign o_rsp_valid   = sel ? if4.rsp_valid   : if1.rsp_valid;
  assign o_rsp_rdata   = sel ? if4.rsp_rdata   : if1.rsp_rdata;
  assign o_rsp_err     = sel ? if4.rsp_err     : if1.rsp_err;
  assign o_rsp_timeout = sel ? if4.rsp_timeout : if1.rsp_timeout;
  assign o_pclken      = sel ? if4.pclken      : if1.pclken;
  assign o_psel        = sel ? if4.psel        : if1.psel;
  assign o_penable     = sel ? if4.penable     : if1.penable;
  assign o_paddr       = sel ? if4.paddr       : if1.paddr;
  assign o_pwrite      = sel ? if4.pwrite      : if1.pwrite;
  assign o_pwdata      = sel ? if4.pwdata      : if1.pwdata;

  // Slave configuration, slave memory and the reference model's own memory.
  int          slv_wait;
  logic        slv_err;
  logic [31:0] slv_mem [0:2047];
  logic [31:0] ref_mem [0:2047];

  // Monitor statistics for the most recent transfer.
  int            acc_ticks, psel_cyc, pen_cyc;
  logic [AW-1:0] mon_paddr;
  logic          mon_pwrite;
  logic [31:0]   mon_pwdata;

  // Monitor + slave: check the previous edge's APB behaviour, then drive the
  // slave response for the coming edge. Outside ACCESS ticks the slave drives
  // junk that the master must ignore.
  initial begin : mon_slave
    logic          p_psel, p_pen, p_pclken, p_pready;
    logic [AW-1:0] p_paddr;
    logic          p_pwrite;
    logic [31:0]   p_pwdata;
    logic [31:0]   r;
    p_psel = 0; p_pen = 0; p_pclken = 0; p_pready = 0;
    p_paddr = '0; p_pwrite = 0; p_pwdata = '0;
    pready = 0; pslverr = 0; prdata = '0;
    acc_ticks = 0; psel_cyc = 0; pen_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        p_psel = 0; p_pen = 0; p_pclken = 0; p_pready = 0;
        acc_ticks = 0;
        pready = 0;
      end else begin
        if (o_penable && !o_psel) begin
          mismatched++;
          $display("FAIL inv_penable_psel: penable=1 psel=0 at %0t", $time);
        end
        if (o_psel && !p_psel) begin
          psel_cyc = 0; pen_cyc = 0; acc_ticks = 0;
          mon_paddr = o_paddr; mon_pwrite = o_pwrite; mon_pwdata = o_pwdata;
        end
        if (o_psel) psel_cyc++;
        if (o_penable) pen_cyc++;
        if (p_psel && o_psel) begin
          compared++;
          if (o_paddr !== p_paddr || o_pwrite !== p_pwrite || o_pwdata !== p_pwdata) begin
            mismatched++;
            $display("FAIL apb_stable: addr %h->%h wr %b->%b data %h->%h at %0t",
                     p_paddr, o_paddr, p_pwrite, o_pwrite, p_pwdata, o_pwdata, $time);
          end
        end
        if (p_psel && !p_pen && o_penable && !p_pclken) begin
          mismatched++;
          $display("FAIL setup_off_tick: ACCESS entered without tick at %0t", $time);
        end
        if (p_psel && !p_pen && p_pclken && !o_penable) begin
          mismatched++;
          $display("FAIL setup_stuck: SETUP held across tick at %0t", $time);
        end
        if (p_pen && !o_psel && !p_pclken) begin
          mismatched++;
          $display("FAIL access_off_tick: ACCESS left without tick at %0t", $time);
        end
        if (p_pen && p_pclken && p_pready && o_penable) begin
          mismatched++;
          $display("FAIL access_stuck: pready=1 tick did not complete at %0t", $time);
        end
        if (p_pen && o_psel && !o_penable) begin
          mismatched++;
          $display("FAIL chained: psel stayed high after ACCESS at %0t", $time);
        end
        r = $urandom;
        if (o_psel && o_penable && o_pclken) begin
          pready  = (acc_ticks >= slv_wait);
          pslverr = pready ? slv_err : r[1];
          prdata  = pready ? slv_mem[o_paddr[AW-1:2]] : $urandom;
          if (pready && o_pwrite && !slv_err) slv_mem[o_paddr[AW-1:2]] = o_pwdata;
          acc_ticks++;
        end else begin
          pready = r[0]; pslverr = r[1]; prdata = $urandom;
        end
        p_psel = o_psel; p_pen = o_penable; p_pclken = o_pclken; p_pready = pready;
        p_paddr = o_paddr; p_pwrite = o_pwrite; p_pwdata = o_pwdata;
      end
    end
  end

  // Waits for rsp_valid (bounded), captures it, optionally holds off and acks.
  task automatic wait_rsp(input int hold, input bit ack, output int lat,
                          output logic [31:0] rd, output logic e, output logic t);
    lat = 1;
    @(negedge clk);
    while (!o_rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    compared++;
    if (!o_rsp_valid) begin
      mismatched++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d clk, required 1", o_rsp_valid, lat);
    end
    rd = o_rsp_rdata; e = o_rsp_err; t = o_rsp_timeout;
    repeat (hold) @(negedge clk);
    if (ack) begin
      rsp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 0;
    end
  endtask

  // Issues one command and collects its response; lat counts clk edges from
  // the accepting edge (inclusive) to rsp_valid visible.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input int waits, input logic serr, input int hold, input bit ack,
                         output int lat, output logic [31:0] rd, output logic e, output logic t);
    int n;
    slv_wait = waits; slv_err = serr;
    req_write = wr; req_addr = addr; req_wdata = wdata; req_valid = 1;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (!o_req_ready) begin
      mismatched++;
      $display("FAIL req_accept: req_ready=%b after %0d clk, required 1", o_req_ready, n);
    end
    @(posedge clk);
    #1 req_valid = 0;
    wait_rsp(hold, ack, lat, rd, e, t);
  endtask

  task automatic test_reset();
    int k;
    reset = 0; sel = 0;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    slv_wait = 0; slv_err = 0;
    #23;
    compared++;
    if ({if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.rsp_timeout, if1.pclken,
         if1.psel, if1.penable, if1.pwrite} !== 8'h00 ||
        if1.rsp_rdata !== 32'h0 || if1.paddr !== '0 || if1.pwdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_out_div1: ready=%b valid=%b pclken=%b psel=%b, required all 0",
               if1.req_ready, if1.rsp_valid, if1.pclken, if1.psel);
    end
    compared++;
    if ({if4.req_ready, if4.rsp_valid, if4.rsp_err, if4.rsp_timeout, if4.pclken,
         if4.psel, if4.penable, if4.pwrite} !== 8'h00 ||
        if4.rsp_rdata !== 32'h0 || if4.paddr !== '0 || if4.pwdata !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_out_div4: ready=%b valid=%b pclken=%b psel=%b, required all 0",
               if4.req_ready, if4.rsp_valid, if4.pclken, if4.psel);
    end
    @(negedge clk);
    reset = 1;
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      compared++;
      if (if1.pclken !== 1'b1 || if4.pclken !== ((k % 4) == 3)) begin
        mismatched++;
        $display("FAIL pclken_seq edge %0d: div1=%b div4=%b, required 1 and %0b",
                 k, if1.pclken, if4.pclken, (k % 4) == 3);
      end
    end
    compared++;
    if (if1.req_ready !== 1'b1 || if4.req_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL idle_ready: div1=%b div4=%b, required 1", if1.req_ready, if4.req_ready);
    end
  endtask

  // Minimum-latency write on the undivided instance.
  task automatic test_write_div1();
    int lat; logic [31:0] rd; logic e, t;
    sel = 0;
    run_txn(1, 13'h004, 32'hDEAD_BEEF, 0, 0, 0, 1, lat, rd, e, t);
    ref_mem[1] = 32'hDEAD_BEEF;
    compared++;
    if (lat !== 3 || psel_cyc !== 2 || pen_cyc !== 1) begin
      mismatched++;
      $display("FAIL write_timing: lat=%0d psel=%0d penable=%0d, required 3 2 1",
               lat, psel_cyc, pen_cyc);
    end
    compared++;
    if (mon_paddr !== 13'h004 || mon_pwdata !== 32'hDEAD_BEEF || mon_pwrite !== 1'b1) begin
      mismatched++;
      $display("FAIL write_bus: paddr=%h pwdata=%h pwrite=%b, required 004 deadbeef 1",
               mon_paddr, mon_pwdata, mon_pwrite);
    end
    compared++;
    if (rd !== 32'h0 || e !== 1'b0 || t !== 1'b0 || slv_mem[1] !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("FAIL write_rsp: rdata=%h err=%b to=%b mem=%h, required 0 0 0 deadbeef",
               rd, e, t, slv_mem[1]);
    end
  endtask

  // Read with unaligned address on the divide-by-4 instance.
  task automatic test_read_div4();
    int lat; logic [31:0] rd; logic e, t;
    sel = 1;
    slv_mem[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
    run_txn(0, 13'h013, 32'hFFFF_FFFF, 0, 0, 0, 1, lat, rd, e, t);
    compared++;
    if (mon_paddr !== 13'h010 || mon_pwrite !== 1'b0 || mon_pwdata !== 32'h0) begin
      mismatched++;
      $display("FAIL read_bus: paddr=%h pwrite=%b pwdata=%h, required 010 0 0",
               mon_paddr, mon_pwrite, mon_pwdata);
    end
    compared++;
    if (rd !== 32'h1234_5678 || e !== 1'b0 || t !== 1'b0) begin
      mismatched++;
      $display("FAIL read_rsp: rdata=%h err=%b to=%b, required 12345678 0 0", rd, e, t);
    end
    compared++;
    if (pen_cyc !== 4 || acc_ticks !== 1 || psel_cyc < 5 || psel_cyc > 8 || lat < 6 || lat > 9) begin
      mismatched++;
      $display("FAIL read_div4_timing: penable=%0d ticks=%0d psel=%0d lat=%0d, required 4 1 5..8 6..9",
               pen_cyc, acc_ticks, psel_cyc, lat);
    end
  endtask

  // Three wait ticks then completion with pslverr.
  task automatic test_wait_err();
    int lat; logic [31:0] rd; logic e, t;
    sel = 1;
    run_txn(0, 13'h010, 32'h0, 3, 1, 0, 1, lat, rd, e, t);
    compared++;
    if (acc_ticks !== 4 || pen_cyc !== 16) begin
      mismatched++;
      $display("FAIL wait_ticks: ticks=%0d penable=%0d, required 4 16", acc_ticks, pen_cyc);
    end
    compared++;
    if (rd !== ref_mem[4] || e !== 1'b1 || t !== 1'b0) begin
      mismatched++;
      $display("FAIL wait_err_rsp: rdata=%h err=%b to=%b, required %h 1 0", rd, e, t, ref_mem[4]);
    end
  endtask

  // Stuck slave aborts after TO ticks; boundary TO-1 waits completes; then normal.
  task automatic test_timeout();
    int lat; logic [31:0] rd; logic e, t;
    sel = 0;
    run_txn(0, 13'h020, 32'h0, 1000, 0, 0, 0, lat, rd, e, t);
    compared++;
    if (rd !== 32'h0 || e !== 1'b1 || t !== 1'b1 || acc_ticks !== TO ||
        o_psel !== 1'b0 || o_penable !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_rsp: rdata=%h err=%b to=%b ticks=%0d psel=%b pen=%b, required 0 1 1 %0d 0 0",
               rd, e, t, acc_ticks, o_psel, o_penable, TO);
    end
    rsp_ready = 1; @(posedge clk); @(negedge clk); rsp_ready = 0;
    run_txn(0, 13'h024, 32'h0, TO - 1, 0, 0, 1, lat, rd, e, t);
    compared++;
    if (rd !== ref_mem[9] || e !== 1'b0 || t !== 1'b0 || acc_ticks !== TO) begin
      mismatched++;
      $display("FAIL timeout_edge: rdata=%h err=%b to=%b ticks=%0d, required %h 0 0 %0d",
               rd, e, t, acc_ticks, ref_mem[9], TO);
    end
    run_txn(1, 13'h028, 32'hA5A5_0001, 0, 0, 0, 1, lat, rd, e, t);
    ref_mem[10] = 32'hA5A5_0001;
    compared++;
    if (e !== 1'b0 || t !== 1'b0 || lat !== 3 || slv_mem[10] !== 32'hA5A5_0001) begin
      mismatched++;
      $display("FAIL after_timeout: err=%b to=%b lat=%0d mem=%h, required 0 0 3 a5a50001",
               e, t, lat, slv_mem[10]);
    end
  endtask

  // Response back-pressure with a new command already pending.
  task automatic test_back_to_back();
    int lat, n; logic [31:0] rd, rd2; logic e, t, e2, t2;
    sel = 0;
    run_txn(1, 13'h030, 32'h0BAD_F00D, 0, 1, 0, 0, lat, rd, e, t);
    req_write = 0; req_addr = 13'h008; req_wdata = '0; req_valid = 1;
    slv_wait = 1; slv_err = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      compared++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b1 ||
          o_rsp_timeout !== 1'b0 || o_req_ready !== 1'b0 || o_psel !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_%0d: valid=%b rdata=%h err=%b to=%b ready=%b psel=%b, required 1 0 1 0 0 0",
                 k, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout, o_req_ready, o_psel);
      end
    end
    rsp_ready = 1; @(posedge clk); @(negedge clk); rsp_ready = 0;
    compared++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_psel !== 1'b0) begin
      mismatched++;
      $display("FAIL released: valid=%b ready=%b psel=%b, required 0 1 0",
               o_rsp_valid, o_req_ready, o_psel);
    end
    @(posedge clk);
    #1 req_valid = 0;
    n = 0;
    wait_rsp(0, 1, n, rd2, e2, t2);
    compared++;
    if (mon_paddr !== 13'h008 || rd2 !== ref_mem[2] || e2 !== 1'b0 || t2 !== 1'b0 || acc_ticks !== 2) begin
      mismatched++;
      $display("FAIL pending_cmd: paddr=%h rdata=%h err=%b to=%b ticks=%0d, required 008 %h 0 0 2",
               mon_paddr, rd2, e2, t2, acc_ticks, ref_mem[2]);
    end
  endtask

  // Reset during ACCESS: bus drops at once, divider restarts, no response.
  task automatic test_reset_mid();
    int n;
    sel = 1; slv_wait = 10; slv_err = 0;
    req_write = 0; req_addr = 13'h040; req_valid = 1;
    n = 0;
    while (!(o_psel && o_penable) && n < 40) begin
      @(negedge clk);
      if (o_psel) req_valid = 0;
      n++;
    end
    req_valid = 0;
    compared++;
    if (!(o_psel && o_penable)) begin
      mismatched++;
      $display("FAIL reach_access: psel=%b penable=%b after %0d clk, required 1 1", o_psel, o_penable, n);
    end
    #2 reset = 0;
    #1;
    compared++;
    if (if4.psel !== 1'b0 || if4.penable !== 1'b0 || if4.rsp_valid !== 1'b0 ||
        if4.pclken !== 1'b0 || if4.req_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: psel=%b pen=%b valid=%b pclken=%b ready=%b, required all 0",
               if4.psel, if4.penable, if4.rsp_valid, if4.pclken, if4.req_ready);
    end
    @(negedge clk);
    reset = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      compared++;
      if (if4.pclken !== ((k % 4) == 3) || if4.req_ready !== 1'b1 ||
          if4.rsp_valid !== 1'b0 || if4.psel !== 1'b0) begin
        mismatched++;
        $display("FAIL post_reset edge %0d: pclken=%b ready=%b valid=%b psel=%b, required %0b 1 0 0",
                 k, if4.pclken, if4.req_ready, if4.rsp_valid, if4.psel, (k % 4) == 3);
      end
    end
  endtask

  // Random transactions on both instances against the transaction-level model.
  task automatic test_random();
    int lat, waits, div, exp_ticks; logic [31:0] rd, wd, exp_rd;
    logic e, t, wr, serr, exp_to; logic [AW-1:0] addr; int w;
    for (int i = 0; i < 24; i++) begin
      sel   = 1'($urandom_range(1, 0));
      div   = sel ? 4 : 1;
      wr    = 1'($urandom_range(1, 0));
      addr  = AW'($urandom);
      wd    = $urandom;
      waits = ($urandom_range(3, 0) == 0) ? $urandom_range(20, 14) : $urandom_range(4, 0);
      serr  = ($urandom_range(3, 0) == 0);
      run_txn(wr, addr, wd, waits, serr, $urandom_range(3, 0), 1, lat, rd, e, t);
      w         = int'(addr >> 2);
      exp_to    = (waits >= TO);
      exp_ticks = exp_to ? TO : waits + 1;
      exp_rd    = (wr || exp_to) ? 32'h0 : ref_mem[w];
      if (wr && !exp_to && !serr) ref_mem[w] = wd;
      compared++;
      if (rd !== exp_rd || e !== (exp_to | serr) || t !== exp_to) begin
        mismatched++;
        $display("FAIL rand_rsp %0d: rdata=%h err=%b to=%b, required %h %b %b",
                 i, rd, e, t, exp_rd, exp_to | serr, exp_to);
      end
      compared++;
      if (mon_paddr !== AW'(w * 4) || mon_pwrite !== wr || mon_pwdata !== (wr ? wd : 32'h0) ||
          acc_ticks !== exp_ticks || pen_cyc !== div * exp_ticks) begin
        mismatched++;
        $display("FAIL rand_bus %0d: paddr=%h wr=%b wdata=%h ticks=%0d pen=%0d, required %h %b %h %0d %0d",
                 i, mon_paddr, mon_pwrite, mon_pwdata, acc_ticks, pen_cyc,
                 AW'(w * 4), wr, wr ? wd : 32'h0, exp_ticks, div * exp_ticks);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      slv_mem[i] = 32'hC0DE_0000 ^ i;
      ref_mem[i] = 32'hC0DE_0000 ^ i;
    end
    test_reset();
    test_write_div1();
    test_read_div4();
    test_wait_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    for (int k = 0; k < 2048; k++) begin
      if (slv_mem[k] !== ref_mem[k]) begin
        compared++;
        mismatched++;
        $display("FAIL mem_final[%0d]: slave=%h, required %h", k, slv_mem[k], ref_mem[k]);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched",
             compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
